// File: rtl/stream_xbar_pkg.sv
// Shared types and constants for the stream crossbar blocks.
package stream_xbar_pkg;

    typedef enum logic {ARB_IDLE, ARB_BUSY} arb_state_t;

    localparam int unsigned BEAT_CNT_W = 16;

endpackage

// File: rtl/rr_pick.sv
// Round-robin pick: first set request strictly after ptr_i, wrapping modulo N.
module rr_pick #(
    parameter int unsigned N  = 4,
    parameter int unsigned IW = $clog2(N)
) (
    input  logic [N-1:0]  req_i,
    input  logic [IW-1:0] ptr_i,
    output logic [N-1:0]  onehot_o,
    output logic [IW-1:0] index_o,
    output logic          any_o
);

    int unsigned scan_idx;

    // ptr_i is always < N, so a single conditional subtract implements the wrap.
    always_comb begin
        onehot_o = '0;
        index_o  = '0;
        any_o    = 1'b0;
        scan_idx = 0;
        for (int unsigned off = 1; off <= N; off++) begin
            scan_idx = 32'(ptr_i) + off;
            if (scan_idx >= N) begin
                scan_idx = scan_idx - N;
            end
            if (!any_o && req_i[scan_idx]) begin
                any_o              = 1'b1;
                index_o            = IW'(scan_idx);
                onehot_o[scan_idx] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/stream_xbar_arbiter.sv
// Packet-level round-robin arbiter for one master port of stream_xbar.
// Locks the grant from selection until the last beat of the packet is accepted.
module stream_xbar_arbiter
    import stream_xbar_pkg::*;
#(
    parameter int unsigned S_DATA_COUNT  = 10,
    parameter int unsigned ID_WIDTH      = $clog2(S_DATA_COUNT),
    parameter int unsigned MAX_PKT_BEATS = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [S_DATA_COUNT-1:0] req_i,
    input  logic                    m_valid_i,
    input  logic                    m_ready_i,
    input  logic                    m_last_i,
    output logic [S_DATA_COUNT-1:0] grant_o,
    output logic [ID_WIDTH-1:0]     grant_id_o,
    output logic                    grant_valid_o,
    output logic [BEAT_CNT_W-1:0]   beat_cnt_o,
    output logic                    overlong_o
);

    arb_state_t                state_q, state_d;
    logic [ID_WIDTH-1:0]       rr_ptr_q, rr_ptr_d;
    logic [S_DATA_COUNT-1:0]   grant_q, grant_d;
    logic [ID_WIDTH-1:0]       grant_id_q, grant_id_d;
    logic [BEAT_CNT_W-1:0]     beat_cnt_q, beat_cnt_d;
    logic                      overlong_q, overlong_d;

    logic [S_DATA_COUNT-1:0]   pick_onehot;
    logic [ID_WIDTH-1:0]       pick_index;
    logic                      pick_any;
    logic                      beat_c;
    logic                      hit_max_c;

    rr_pick #(
        .N  (S_DATA_COUNT),
        .IW (ID_WIDTH)
    ) u_rr_pick (
        .req_i    (req_i),
        .ptr_i    (rr_ptr_q),
        .onehot_o (pick_onehot),
        .index_o  (pick_index),
        .any_o    (pick_any)
    );

    assign beat_c = (state_q == ARB_BUSY) && m_valid_i && m_ready_i;

    // Counter passes MAX_PKT_BEATS exactly once per packet, so the pulse is unique.
    assign hit_max_c = (MAX_PKT_BEATS != 0) &&
                       ((17'(beat_cnt_q) + 17'd1) == 17'(MAX_PKT_BEATS));

    always_comb begin
        state_d    = state_q;
        rr_ptr_d   = rr_ptr_q;
        grant_d    = grant_q;
        grant_id_d = grant_id_q;
        beat_cnt_d = beat_cnt_q;
        overlong_d = 1'b0;
        case (state_q)
            ARB_IDLE: begin
                if (pick_any) begin
                    state_d    = ARB_BUSY;
                    grant_d    = pick_onehot;
                    grant_id_d = pick_index;
                    rr_ptr_d   = pick_index;
                    beat_cnt_d = '0;
                end
            end
            ARB_BUSY: begin
                if (beat_c) begin
                    if (beat_cnt_q != '1) begin
                        beat_cnt_d = beat_cnt_q + BEAT_CNT_W'(1);
                    end
                    if (m_last_i) begin
                        state_d = ARB_IDLE;
                        grant_d = '0;
                    end else if (hit_max_c) begin
                        overlong_d = 1'b1;
                    end
                end
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q    <= ARB_IDLE;
            rr_ptr_q   <= ID_WIDTH'(S_DATA_COUNT - 1);
            grant_q    <= '0;
            grant_id_q <= '0;
            beat_cnt_q <= '0;
            overlong_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            rr_ptr_q   <= rr_ptr_d;
            grant_q    <= grant_d;
            grant_id_q <= grant_id_d;
            beat_cnt_q <= beat_cnt_d;
            overlong_q <= overlong_d;
        end
    end

    assign grant_o       = grant_q;
    assign grant_id_o    = grant_id_q;
    assign grant_valid_o = (state_q == ARB_BUSY);
    assign beat_cnt_o    = beat_cnt_q;
    assign overlong_o    = overlong_q;

    a_grant_onehot0: assert property (@(posedge clk) disable iff (reset) $onehot0(grant_q));

endmodule

// File: tb/tb_stream_xbar_arbiter.sv
// Directed bench for stream_xbar_arbiter with 4 requesters and an 8-beat overlong threshold.
module tb_stream_xbar_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic [3:0]  req;
    logic        m_valid;
    logic        m_ready;
    logic        m_last;
    logic [3:0]  grant;
    logic [1:0]  grant_id;
    logic        grant_valid;
    logic [15:0] beat_cnt;
    logic        overlong;

    int errors = 0;
    int checks = 0;

    stream_xbar_arbiter #(
        .S_DATA_COUNT  (4),
        .ID_WIDTH      (2),
        .MAX_PKT_BEATS (8)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .req_i         (req),
        .m_valid_i     (m_valid),
        .m_ready_i     (m_ready),
        .m_last_i      (m_last),
        .grant_o       (grant),
        .grant_id_o    (grant_id),
        .grant_valid_o (grant_valid),
        .beat_cnt_o    (beat_cnt),
        .overlong_o    (overlong)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_grant(input string tag, input logic [3:0] g, input logic [1:0] id, input logic v);
        chk({tag, ".grant"}, 32'(grant), 32'(g));
        chk({tag, ".id"}, 32'(grant_id), 32'(id));
        chk({tag, ".valid"}, 32'(grant_valid), 32'(v));
    endtask

    logic [1:0] seq1 [5];
    logic [3:0] pending;
    int         wait_cnt [4];
    logic       prev_gv;

    initial begin
        seq1[0] = 2'd0; seq1[1] = 2'd1; seq1[2] = 2'd2; seq1[3] = 2'd3; seq1[4] = 2'd0;
        reset   = 1'b1;
        req     = 4'b0000;
        m_valid = 1'b0;
        m_ready = 1'b0;
        m_last  = 1'b0;
        tick();
        tick();
        chk_grant("reset", 4'b0000, 2'd0, 1'b0);
        chk("reset.beat_cnt", 32'(beat_cnt), 32'd0);
        chk("reset.overlong", 32'(overlong), 32'd0);
        reset = 1'b0;

        // 1: all requesting, single-beat packets -> 0,1,2,3,0 with one idle gap each
        req = 4'b1111; m_valid = 1'b1; m_ready = 1'b1; m_last = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk_grant("t1.grant", 4'b0001 << seq1[i], seq1[i], 1'b1);
            if (i == 4) req = 4'b0000;
            tick();
            chk_grant("t1.gap", 4'b0000, seq1[i], 1'b0);
        end
        m_valid = 1'b0; m_last = 1'b0;

        // 2: grant frozen while another slave requests mid-packet
        req = 4'b0100;
        tick();
        chk_grant("t2.grant", 4'b0100, 2'd2, 1'b1);
        req = 4'b0001;
        tick();
        chk_grant("t2.hold_novalid", 4'b0100, 2'd2, 1'b1);
        m_valid = 1'b1;
        tick();
        chk_grant("t2.hold_beat", 4'b0100, 2'd2, 1'b1);
        chk("t2.beat_cnt", 32'(beat_cnt), 32'd1);
        m_last = 1'b1;
        tick();
        chk_grant("t2.end", 4'b0000, 2'd2, 1'b0);
        tick();
        chk_grant("t2.next", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000;
        tick();
        chk_grant("t2.end2", 4'b0000, 2'd0, 1'b0);
        m_valid = 1'b0; m_last = 1'b0;

        // 3: 5-beat packet with a 3-cycle ready stall
        req = 4'b0010;
        tick();
        chk_grant("t3.grant", 4'b0010, 2'd1, 1'b1);
        chk("t3.cnt0", 32'(beat_cnt), 32'd0);
        req = 4'b0000; m_valid = 1'b1; m_ready = 1'b1;
        tick(); chk("t3.cnt1", 32'(beat_cnt), 32'd1);
        tick(); chk("t3.cnt2", 32'(beat_cnt), 32'd2);
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t3.stall_cnt", 32'(beat_cnt), 32'd2);
            chk_grant("t3.stall", 4'b0010, 2'd1, 1'b1);
        end
        m_ready = 1'b1;
        tick(); chk("t3.cnt3", 32'(beat_cnt), 32'd3);
        tick(); chk("t3.cnt4", 32'(beat_cnt), 32'd4);
        m_last = 1'b1;
        tick();
        chk("t3.cnt5", 32'(beat_cnt), 32'd5);
        chk_grant("t3.end", 4'b0000, 2'd1, 1'b0);
        m_valid = 1'b0; m_last = 1'b0;
        tick();
        chk("t3.cnt_hold", 32'(beat_cnt), 32'd5);

        // 4: 10-beat packet, overlong pulse on beat 8 only, release after beat 10
        req = 4'b0100;
        tick();
        chk_grant("t4.grant", 4'b0100, 2'd2, 1'b1);
        req = 4'b0000; m_valid = 1'b1; m_ready = 1'b1;
        for (int b = 1; b <= 10; b++) begin
            if (b == 10) m_last = 1'b1;
            tick();
            chk("t4.cnt", 32'(beat_cnt), 32'(b));
            chk("t4.overlong", 32'(overlong), 32'(b == 8));
            if (b < 10) chk_grant("t4.hold", 4'b0100, 2'd2, 1'b1);
        end
        chk_grant("t4.end", 4'b0000, 2'd2, 1'b0);
        m_valid = 1'b0; m_last = 1'b0;

        // 5: async reset while BUSY at beat 3
        req = 4'b0001;
        tick();
        chk_grant("t5.grant", 4'b0001, 2'd0, 1'b1);
        req = 4'b0000; m_valid = 1'b1;
        tick(); tick(); tick();
        chk("t5.cnt3", 32'(beat_cnt), 32'd3);
        reset = 1'b1;
        #1;
        chk_grant("t5.async", 4'b0000, 2'd0, 1'b0);
        chk("t5.async_cnt", 32'(beat_cnt), 32'd0);
        tick();
        reset = 1'b0; req = 4'b1000; m_valid = 1'b0;
        tick();
        chk_grant("t5.after", 4'b1000, 2'd3, 1'b1);
        chk("t5.after_cnt", 32'(beat_cnt), 32'd0);
        req = 4'b0000; m_valid = 1'b1; m_last = 1'b1;
        tick();
        chk_grant("t5.end", 4'b0000, 2'd3, 1'b0);
        m_valid = 1'b0; m_last = 1'b0;

        // 6: random traffic with sticky requests; one-hot grants and bounded waits
        pending = 4'b0000;
        prev_gv = 1'b0;
        for (int s = 0; s < 4; s++) wait_cnt[s] = 0;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            tick();
            chk("t6.onehot0", 32'($onehot0(grant)), 32'd1);
            if (grant_valid && !prev_gv) begin
                chk("t6.grant_was_req", 32'((grant & pending) != 4'b0000), 32'd1);
                for (int s = 0; s < 4; s++) begin
                    if (grant[s]) begin
                        pending[s]  = 1'b0;
                        wait_cnt[s] = 0;
                    end else if (pending[s]) begin
                        wait_cnt[s]++;
                        chk("t6.starve", 32'(wait_cnt[s] <= 3), 32'd1);
                    end
                end
            end
            prev_gv = grant_valid;
            for (int s = 0; s < 4; s++) begin
                if (!pending[s]) pending[s] = ($urandom_range(0, 2) == 0);
            end
            req     = pending;
            m_valid = ($urandom_range(0, 3) != 0);
            m_ready = ($urandom_range(0, 3) != 0);
            m_last  = ($urandom_range(0, 3) == 0);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
